// File: rtl/ror_seq_unit.sv
// Multi-cycle rotate-right unit: rotates one bit per clock behind a start/done handshake.
// Optional ROR_SHORTPATH_EN: amounts above WIDTH/2 rotate left by WIDTH-amount instead.
module ror_seq_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AMT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic [AMT_W-1:0] amount,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        StIdle,
        StRot,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] opr_q, opr_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] opr_step;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [AMT_W-1:0] cap_cnt;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

`ifdef ROR_SHORTPATH_EN
    logic left_q, left_d;
    logic cap_left;

    // Long right rotations are replaced by the shorter left rotation; direction latched at capture.
    assign cap_left = amount > AMT_W'(WIDTH / 2);
    assign cap_cnt  = cap_left ? AMT_W'(WIDTH - 32'(amount)) : amount;
    assign opr_step = left_q ? {opr_q[WIDTH-2:0], opr_q[WIDTH-1]}
                             : {opr_q[0], opr_q[WIDTH-1:1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            left_q <= 1'b0;
        end else begin
            left_q <= left_d;
        end
    end

    always_comb begin
        left_d = left_q;
        if (state_q == StIdle && start) begin
            left_d = cap_left;
        end
    end
`else
    assign cap_cnt  = amount;
    assign opr_step = {opr_q[0], opr_q[WIDTH-1:1]};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            opr_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            opr_q    <= opr_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        opr_d    = opr_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    opr_d = data_in;
                    cnt_d = cap_cnt;
                    if (cap_cnt == '0) begin
                        // Zero rotation completes straight from capture.
                        result_d = data_in;
                        done_d   = 1'b1;
                        state_d  = StDone;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = StRot;
                    end
                end
            end
            StRot: begin
                opr_d = opr_step;
                cnt_d = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    result_d = opr_step;
                    done_d   = 1'b1;
                    state_d  = StDone;
                end else begin
                    busy_d = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign ready  = (state_q == StIdle);
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_ror_seq_unit.sv
// Bench for ror_seq_unit: timeline-based reference model, per-cycle compare, directed and random ops.
module tb_ror_seq_unit;

    localparam int W = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] data_in = '0;
    logic [4:0]  amount = '0;
    logic        ready, busy, done;
    logic [31:0] result;

    int n_checks = 0;
    int n_errors = 0;

    // Model: an op accepted at edge number c0 with effective count n shows busy in cycles
    // c0..c0+n-1, done in cycle c0+n, and is idle again from c0+n+1.
    int          cyc = 0;
    int          m_c0 = -100;
    int          m_n = 0;
    logic [31:0] m_pend = '0;
    logic [31:0] m_result = '0;

    ror_seq_unit #(
        .WIDTH(32),
        .AMT_W(5)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .data_in(data_in),
        .amount (amount),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ror_ref(input logic [31:0] x, input logic [4:0] a);
        if (a == 0) return x;
        return (x >> a) | (x << (W - int'(a)));
    endfunction

    function automatic int eff_n(input logic [4:0] a);
`ifdef ROR_SHORTPATH_EN
        return (int'(a) > W / 2) ? W - int'(a) : int'(a);
`else
        return int'(a);
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_c0     <= -100;
            m_n      <= 0;
            m_result <= '0;
        end else if (start && cyc > m_c0 + m_n) begin
            m_c0   <= cyc + 1;
            m_n    <= eff_n(amount);
            m_pend <= ror_ref(data_in, amount);
            if (eff_n(amount) == 0) m_result <= ror_ref(data_in, amount);
        end else if (m_n > 0 && cyc + 1 == m_c0 + m_n) begin
            m_result <= m_pend;
        end
    end

    always @(negedge clk) begin
        logic active;
        active = (cyc <= m_c0 + m_n);
        chk("ready", {31'b0, ready}, {31'b0, !active});
        chk("busy", {31'b0, busy}, {31'b0, active && cyc < m_c0 + m_n});
        chk("done", {31'b0, done}, {31'b0, active && cyc == m_c0 + m_n});
        chk("result", result, m_result);
    end

    // Issue one op, wait for done; pins result and busy length with literal expectations.
    task automatic do_op(input logic [31:0] d, input logic [4:0] a, input logic [31:0] er,
                         input int eb, input string nm);
        int bc;
        bit seen;
        @(negedge clk); #1;
        start = 1'b1; data_in = d; amount = a;
        @(negedge clk); #1;
        start = 1'b0; data_in = $urandom; amount = 5'($urandom);
        bc = 0;
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (done) begin
                seen = 1;
            end else begin
                if (busy) bc++;
                @(negedge clk); #1;
            end
        end
        chk({nm, "_done_seen"}, {31'b0, seen}, 32'd1);
        chk({nm, "_result"}, result, er);
        chk({nm, "_busy_cycles"}, 32'(bc), 32'(eb));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("reset_ready", {31'b0, ready}, 32'd1);
        chk("reset_result", result, 32'h0);
        reset = 1'b0;

        do_op(32'h00000001, 5'd1, 32'h80000000, 1, "t1");
        do_op(32'h0000000F, 5'd4, 32'hF0000000, 4, "t2");
        do_op(32'h12345678, 5'd0, 32'h12345678, 0, "t3");
`ifdef ROR_SHORTPATH_EN
        do_op(32'h80000001, 5'd31, 32'h00000003, 1, "t4");
`else
        do_op(32'h80000001, 5'd31, 32'h00000003, 31, "t4");
`endif
        do_op(32'h00000001, 5'd16, 32'h00010000, 16, "half");

        // Start while busy is ignored; start in the idle cycle after done is accepted.
        @(negedge clk); #1;
        start = 1'b1; data_in = 32'h0000000F; amount = 5'd4;
        @(negedge clk); #1;
        start = 1'b0;
        @(negedge clk); #1;
        start = 1'b1; data_in = 32'hFFFF0000; amount = 5'd8;
        @(negedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 10 && !done; k++) begin
            @(negedge clk); #1;
        end
        chk("t5_done", {31'b0, done}, 32'd1);
        chk("t5_result", result, 32'hF0000000);
        @(negedge clk); #1;
        chk("t5_idle_ready", {31'b0, ready}, 32'd1);
        start = 1'b1; data_in = 32'h00000002; amount = 5'd1;
        @(negedge clk); #1;
        start = 1'b0;
        chk("t5_accepted", {31'b0, ready}, 32'd0);
        @(negedge clk); #1;
        chk("t5_second_result", result, 32'h00000001);

        // Reset mid-rotation drops the op with no done pulse.
        @(negedge clk); #1;
        start = 1'b1; data_in = 32'hDEADBEEF; amount = 5'd20;
        @(negedge clk); #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("t6_ready", {31'b0, ready}, 32'd1);
        chk("t6_busy", {31'b0, busy}, 32'd0);
        chk("t6_done", {31'b0, done}, 32'd0);
        chk("t6_result", result, 32'h0);
        @(negedge clk); #1;
        reset = 1'b0;
        do_op(32'h0000F000, 5'd12, 32'h0000000F, eff_n(5'd12), "t6_after");

        // Random traffic, including starts while busy and rare resets.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            reset   = ($urandom_range(0, 399) == 0);
            start   = ($urandom_range(0, 3) == 0);
            data_in = $urandom;
            amount  = 5'($urandom);
        end
        @(negedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        repeat (40) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
